// File: rtl/uart_int_pkg.sv
// Shared constants for the UART interrupt arbiter: FSM states, default sizing, source indices.
`timescale 1ns/1ps
package uart_int_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } arb_state_e;

  localparam int N_SRC_DEF = 4;
  localparam int ID_W_DEF  = 2;

  localparam int SRC_RXRDY = 0;
  localparam int SRC_TXRDY = 1;
  localparam int SRC_FERR  = 2;
  localparam int SRC_OVR   = 3;

endpackage

// File: rtl/uart_int_arb_pos_edge_det.sv
// Single-bit rising-edge detector used once per UART event source.
`timescale 1ns/1ps
module pos_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;
  logic in_d;

  always_comb in_d = in;

  // History keeps tracking the input through reset, so a level held high across reset is not an event.
  always_ff @(posedge clk) begin
    in_q <= in_d;
  end

  assign pulse = in & ~in_q & ~rst;

endmodule

// File: rtl/uart_int_arb.sv
// Interrupt source arbiter feeding the interrupt SR flop; one request in flight until acknowledged.
// Build option UART_INT_RR_ARB_EN selects round-robin grant instead of fixed lowest-index priority.
`timescale 1ns/1ps
module uart_int_arb
  import uart_int_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] evt,
  input  logic             int_busy,
  input  logic             int_ack,
  input  logic             ovr_clr,
  output logic             int_set,
  output logic [ID_W-1:0]  cause_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overrun
);

  // state    | meaning
  // IDLE     | nothing in flight; grant when pending, SR flop clear and no ack
  // ISSUE    | int_set pulse this cycle; granted pending bit is cleared
  // WAIT_ACK | request held at CPU until int_ack

  arb_state_e       state_q, state_d;
  logic             int_set_q, int_set_d;
  logic [ID_W-1:0]  cause_id_q, cause_id_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] overrun_q, overrun_d;
  logic [N_SRC-1:0] evt_edge;
  logic [N_SRC-1:0] issue_clr;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  cand;

  for (genvar g = 0; g < N_SRC; g++) begin : g_edge
    pos_edge_det u_edge (
      .clk   (clk),
      .rst   (rst),
      .in    (evt[g]),
      .pulse (evt_edge[g])
    );
  end

`ifdef UART_INT_RR_ARB_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant = '0;
    cand  = '0;
    for (int k = N_SRC-1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % N_SRC);
      if (pending_q[cand]) grant = cand;
    end
  end
`else
  always_comb begin
    grant = '0;
    cand  = '0;
    for (int i = N_SRC-1; i >= 0; i--) begin
      cand = ID_W'(i);
      if (pending_q[cand]) grant = cand;
    end
  end
`endif

  always_comb begin
    issue_clr = (state_q == ISSUE) ? (N_SRC'(1) << cause_id_q) : '0;
    // A fresh edge on the source being cleared re-arms it and is not an overrun.
    pending_d = (pending_q & ~issue_clr) | evt_edge;
    overrun_d = (ovr_clr ? '0 : overrun_q) | (evt_edge & pending_q & ~issue_clr);
  end

  always_comb begin
    state_d    = state_q;
    int_set_d  = 1'b0;
    cause_id_d = cause_id_q;
`ifdef UART_INT_RR_ARB_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|pending_q && !int_busy && !int_ack) begin
          state_d    = ISSUE;
          int_set_d  = 1'b1;
          cause_id_d = grant;
`ifdef UART_INT_RR_ARB_EN
          rr_ptr_d   = (grant == ID_W'(N_SRC-1)) ? '0 : grant + 1'b1;
`endif
        end
      end
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: if (int_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      int_set_q  <= 1'b0;
      cause_id_q <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
`ifdef UART_INT_RR_ARB_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      int_set_q  <= int_set_d;
      cause_id_q <= cause_id_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
`ifdef UART_INT_RR_ARB_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign int_set  = int_set_q;
  assign cause_id = cause_id_q;
  assign pending  = pending_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_int_arb.sv
// Randomized and directed bench for uart_int_arb against a cycle-level reference model.
`timescale 1ns/1ps
module tb_uart_int_arb;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  evt;
  logic          int_busy;
  logic          int_ack;
  logic          ovr_clr;
  logic          int_set;
  logic [IW-1:0] cause_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  overrun;

  always #5 clk = ~clk;

  uart_int_arb #(.N_SRC(N), .ID_W(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .evt      (evt),
    .int_busy (int_busy),
    .int_ack  (int_ack),
    .ovr_clr  (ovr_clr),
    .int_set  (int_set),
    .cause_id (cause_id),
    .pending  (pending),
    .overrun  (overrun)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: event bookkeeping plus "one request outstanding" bookkeeping.
  logic [N-1:0] m_pend = '0, m_ovr = '0, m_prev = '0;
  bit           m_set = 0, m_issuing = 0, m_waiting = 0;
  int           m_cause = 0, m_start = 0;
  logic         sr = 1'b0;

  function automatic int pick(input logic [N-1:0] p, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (p[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model(input logic [N-1:0] e, input logic ack, input logic clr,
                       input logic rs, input logic busy);
    logic [N-1:0] edges, clrm, n_pend, n_ovr;
    int g;
    if (rs) begin
      m_pend = '0; m_ovr = '0; m_set = 0; m_cause = 0;
      m_issuing = 0; m_waiting = 0; m_start = 0; m_prev = e;
      return;
    end
    edges  = e & ~m_prev;
    m_prev = e;
    clrm   = m_issuing ? (N'(1) << m_cause) : '0;
    n_ovr  = (clr ? '0 : m_ovr) | (edges & m_pend & ~clrm);
    n_pend = (m_pend & ~clrm) | edges;
    if (m_issuing) begin
      m_issuing = 0;
      m_waiting = 1;
    end else if (m_waiting) begin
      if (ack) m_waiting = 0;
    end else if (m_pend != '0 && !busy && !ack) begin
      g = pick(m_pend, m_start);
      m_cause   = g;
      m_issuing = 1;
`ifdef UART_INT_RR_ARB_EN
      m_start   = (g + 1) % N;
`endif
    end
    m_set  = m_issuing;
    m_pend = n_pend;
    m_ovr  = n_ovr;
  endtask

  task automatic step(input logic [N-1:0] e, input logic ack, input logic clr,
                      input logic rs, input logic fb);
    logic busy_in, cur_set;
    evt      = e;
    int_ack  = ack;
    ovr_clr  = clr;
    rst      = rs;
    busy_in  = sr | fb;
    int_busy = busy_in;
    cur_set  = int_set;
    @(posedge clk);
    #1;
    model(e, ack, clr, rs, busy_in);
    if (rs)           sr = 1'b0;
    else if (cur_set) sr = 1'b1;
    else if (ack)     sr = 1'b0;
    chk("int_set",  {31'b0, int_set}, {31'b0, m_set});
    chk("cause_id", 32'(cause_id), 32'(m_cause));
    chk("pending",  32'(pending),  32'(m_pend));
    chk("overrun",  32'(overrun),  32'(m_ovr));
  endtask

  task automatic drain(input logic [N-1:0] e);
    int budget;
    budget = 0;
    while ((m_pend != '0 || m_issuing || m_waiting) && budget < 60) begin
      step(e, m_waiting, 1'b0, 1'b0, 1'b0);
      budget++;
    end
    chk("drain_timeout", budget < 60 ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    evt = '0; int_ack = 0; ovr_clr = 0; rst = 1; int_busy = 0;

    // Reset with all events high: nothing is captured on release.
    step(4'hF, 0, 0, 1, 0);
    step(4'hF, 0, 0, 1, 0);
    chk("rst_int_set", {31'b0, int_set}, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    step(4'hF, 0, 0, 0, 0);
    step(4'hF, 0, 0, 0, 0);
    chk("hold_no_pend", 32'(pending), 32'd0);
    step(4'h0, 0, 0, 0, 0);

    // Single event on source 1.
    step(4'b0010, 0, 0, 0, 0);
    chk("t2_pending", 32'(pending), 32'h2);
    step(4'b0010, 0, 0, 0, 0);
    chk("t2_set", {31'b0, int_set}, 32'd1);
    chk("t2_cause", 32'(cause_id), 32'd1);
    step(4'b0010, 0, 0, 0, 0);
    chk("t2_set_low", {31'b0, int_set}, 32'd0);
    step(4'b0010, 1, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0);

    // Two simultaneous events.
    step(4'b0101, 0, 0, 0, 0);
    step(4'b0101, 0, 0, 0, 0);
    chk("t3_first", 32'(cause_id), 32'd0);
    step(4'b0101, 0, 0, 0, 0);
    step(4'b0101, 1, 0, 0, 0);
    step(4'b0101, 0, 0, 0, 0);
    chk("t3_second", 32'(cause_id), 32'd2);
    drain(4'b0000);
    step(4'b0101, 0, 0, 0, 0);
    drain(4'b0000);

    // Overrun on source 0 while held off by busy.
    step(4'b0001, 0, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 1);
    step(4'b0001, 0, 0, 0, 1);
    chk("t4_ovr", 32'(overrun), 32'h1);
    step(4'b0001, 0, 1, 0, 1);
    chk("t4_clr", 32'(overrun), 32'h0);
    drain(4'b0000);

    // Busy holds off source 3 until it drops.
    step(4'b1000, 0, 0, 0, 1);
    step(4'b1000, 0, 0, 0, 1);
    step(4'b1000, 0, 0, 0, 1);
    chk("t5_held", {31'b0, int_set}, 32'd0);
    step(4'b1000, 0, 0, 0, 0);
    chk("t5_set", {31'b0, int_set}, 32'd1);
    chk("t5_cause", 32'(cause_id), 32'd3);
    drain(4'b0000);

    // Reset while waiting for ack with more sources pending.
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0111, 0, 0, 0, 0);
    chk("t6_pend", 32'(pending), 32'h6);
    step(4'b0111, 0, 0, 1, 0);
    chk("t6_rst_pend", 32'(pending), 32'h0);
    step(4'b0111, 0, 0, 0, 0);
    chk("t6_no_set", {31'b0, int_set}, 32'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] e;
      logic a, c, r, f;
      e = ($urandom % 3 == 0) ? N'($urandom_range(0, 15)) : evt;
      a = m_waiting ? ($urandom % 3 == 0) : ($urandom % 12 == 0);
      c = ($urandom % 10 == 0);
      r = ($urandom % 200 == 0);
      f = ($urandom % 5 == 0);
      step(e, a, c, r, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
